fifo_packet_reader: RTL and testbench



---
 rtl/fifo_packet_pkg.sv | 13 +
 rtl/stream_output_reg.sv | 42 ++++
 rtl/fifo_packet_reader.sv | 142 ++++++++++++++
 tb/tb_fifo_packet_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packet_pkg.sv
// Shared types and header constants for the FIFO packet reader and its stream output stage.
package fifo_packet_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StTrailer
  } state_e;

  localparam int unsigned TAG_WIDTH  = 4;
  localparam logic [3:0]  HEADER_TAG = 4'hA;

endpackage

// File: rtl/stream_output_reg.sv
// Single-entry valid/ready output register; a new word may load whenever the slot is free.
module stream_output_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             last_o,
  output logic             valid_o,
  output logic             slot_free_o
);

  logic [Width-1:0] data_q;
  logic             last_q;
  logic             valid_q;

  assign slot_free_o = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (slot_free_o) begin
      valid_q <= load_i;
      // Payload fields only move on a load so a stalled word stays stable.
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_packet_reader.sv
// Drains a FWFT sample FIFO into header + payload (+ checksum) packets on a valid/ready stream.
// Define FIFO_PACKET_READER_CHECKSUM_EN to append a modular-sum trailer word to each packet.
module fifo_packet_reader
  import fifo_packet_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PACKET_LEN = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic [ADDR_WIDTH+1:0] fifo_level,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  underrun
);

  localparam int unsigned         SeqWidth = DATA_WIDTH - TAG_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx  = ADDR_WIDTH'(PACKET_LEN - 1);
  localparam logic [ADDR_WIDTH+1:0] LevelMin = (ADDR_WIDTH + 2)'(PACKET_LEN);

  state_e                state_q;
  logic [SeqWidth-1:0]   seq_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  underrun_q;
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
`endif

  logic                  slot_free;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  payload_last;

  assign payload_last = (count_q == LastIdx);

  always_comb begin
    load         = 1'b0;
    load_data    = '0;
    load_last    = 1'b0;
    fifo_read_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (fifo_level >= LevelMin) && slot_free) begin
          load      = 1'b1;
          load_data = {HEADER_TAG, seq_q};
        end
      end
      StPayload: begin
        // Pop and output load happen on the same edge.
        if (slot_free && !fifo_empty) begin
          load         = 1'b1;
          fifo_read_en = 1'b1;
          load_data    = fifo_dout;
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
          load_last    = 1'b0;
`else
          load_last    = payload_last;
`endif
        end
      end
      StTrailer: begin
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
        if (slot_free) begin
          load      = 1'b1;
          load_data = csum_q;
          load_last = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      seq_q      <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      if ((state_q == StPayload) && fifo_empty) begin
        underrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q <= StPayload;
            seq_q   <= seq_q + SeqWidth'(1);
            count_q <= '0;
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        StPayload: begin
          if (load) begin
            count_q <= count_q + ADDR_WIDTH'(1);
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
            csum_q  <= csum_q + fifo_dout;
            if (payload_last) state_q <= StTrailer;
`else
            if (payload_last) state_q <= StIdle;
`endif
          end
        end
        StTrailer: begin
          if (load) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign underrun = underrun_q;

  stream_output_reg #(
    .Width(DATA_WIDTH)
  ) u_out (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (load),
    .data_i     (load_data),
    .last_i     (load_last),
    .ready_i    (m_ready),
    .data_o     (m_data),
    .last_o     (m_last),
    .valid_o    (m_valid),
    .slot_free_o(slot_free)
  );

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Randomized and directed bench for fifo_packet_reader against a packet-level reference model.
module tb_fifo_packet_reader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int PL = 4;
`ifdef FIFO_PACKET_READER_CHECKSUM_EN
  localparam bit CK  = 1'b1;
  localparam int PKT = PL + 2;
`else
  localparam bit CK  = 1'b0;
  localparam int PKT = PL + 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic [AW+1:0] fifo_level = '0;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          underrun;

  always #5 clk = ~clk;

  fifo_packet_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PACKET_LEN(PL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_level  (fifo_level),
    .fifo_read_en(fifo_read_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .underrun    (underrun)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];     // FIFO contents, head at index 0
  logic [DW-1:0] words[$];  // every word pushed since the last reset
  logic [DW-1:0] acc[$];    // words the DUT handed over (valid && ready)
  logic [DW-1:0] expq[$];
  bit            force_empty = 1'b0;

  // Reference model: expected output register, packet position and sticky flag.
  bit            e_v, e_l, e_u;
  logic [DW-1:0] e_d, sum;
  int            seq, pos;  // pos: 0 idle, k = words of current packet already loaded

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_v = 0; e_l = 0; e_u = 0; e_d = '0; sum = '0; seq = 0; pos = 0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    words.push_back(w);
  endtask

  // One clock: drive FIFO view, check outputs, advance model, pop at the edge.
  task automatic cycle();
    bit            slot, load, pop, nl;
    logic [DW-1:0] nd;
    fifo_empty = force_empty || (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    fifo_level = (AW + 2)'(fq.size());
    #1;
    pop = 0;
    if (!reset) begin
      chk("m_valid", m_valid, e_v);
      if (e_v) begin
        chk("m_data", m_data, e_d);
        chk("m_last", m_last, e_l);
      end
      chk("underrun", underrun, e_u);
      if (m_valid && m_ready) acc.push_back(m_data);
      slot = !e_v || m_ready;
      load = 0; nl = 0; nd = '0;
      if (pos == 0) begin
        if (enable && fifo_level >= PL && slot) begin
          load = 1; nd = {4'hA, 12'(seq)}; seq = (seq + 1) % 4096; sum = '0; pos = 1;
        end
      end else if (pos <= PL) begin
        if (fifo_empty) e_u = 1;
        else if (slot) begin
          load = 1; pop = 1; nd = fifo_dout; sum = sum + fifo_dout; pos++;
          nl = (pos == PL + 1) && !CK;
          if (pos == PKT) pos = 0;
        end
      end else if (slot) begin
        load = 1; nd = sum; nl = 1; pos = 0;
      end
      chk("fifo_read_en", fifo_read_en, pop);
      if (slot) begin
        e_v = load;
        if (load) begin e_d = nd; e_l = nl; end
      end
    end
    @(posedge clk);
    if (reset) model_reset();
    else if (pop) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; force_empty = 0; enable = 0; m_ready = 0;
    fq.delete(); words.delete();
    cycle(); cycle();
    reset = 0;
    acc.delete();
  endtask

  task automatic exp_pkt(input logic [DW-1:0] hdr, input int first);
    logic [DW-1:0] s = '0;
    expq.push_back(hdr);
    for (int i = 0; i < PL; i++) begin
      expq.push_back(words[first + i]);
      s = s + words[first + i];
    end
    if (CK) expq.push_back(s);
  endtask

  task automatic check_acc(input string name);
    chk({name, "_len"}, acc.size(), expq.size());
    for (int i = 0; i < expq.size() && i < acc.size(); i++) chk(name, acc[i], expq[i]);
    expq.delete();
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Basic packet 1,2,3,4 with the stream always ready.
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'(i));
    enable = 1; m_ready = 1;
    for (int i = 0; i < PKT + 1; i++) cycle();
    expq = '{16'hA000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    if (CK) expq.push_back(16'h000A);
    check_acc("basic_stream");
    chk("basic_pops", fq.size(), 0);

    // Three buffered words never start a packet; the fourth does on the next cycle.
    do_reset();
    for (int i = 0; i < 3; i++) push(16'($urandom));
    enable = 1; m_ready = 1;
    for (int i = 0; i < 20; i++) cycle();
    chk("short_level_idle", acc.size(), 0);
    chk("short_level_nopop", fq.size(), 3);
    push(16'($urandom));
    cycle();
    chk("hdr_latency_valid", m_valid, 1);
    chk("hdr_latency_data", m_data, 16'hA000);
    for (int i = 0; i < PKT; i++) cycle();

    // Two packets back-to-back at full throughput.
    do_reset();
    for (int i = 0; i < 8; i++) push(16'($urandom));
    enable = 1; m_ready = 1;
    for (int i = 0; i < 2 * PKT + 1; i++) cycle();
    exp_pkt(16'hA000, 0);
    exp_pkt(16'hA001, 4);
    check_acc("back_to_back");

    // Ready toggling every other cycle.
    do_reset();
    for (int i = 0; i < 8; i++) push(16'($urandom));
    enable = 1;
    for (int i = 0; i < 4 * PKT + 4; i++) begin
      m_ready = i[0];
      cycle();
    end
    exp_pkt(16'hA000, 0);
    exp_pkt(16'hA001, 4);
    check_acc("ready_toggle");

    // FIFO runs dry after two payload words.
    do_reset();
    for (int i = 0; i < 4; i++) push(16'($urandom));
    enable = 1; m_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    force_empty = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("underrun_set", underrun, 1);
    chk("underrun_nopop", fq.size(), 2);
    force_empty = 0;
    for (int i = 0; i < 5; i++) cycle();
    exp_pkt(16'hA000, 0);
    check_acc("underrun_resume");
    chk("underrun_sticky", underrun, 1);

    // Reset in the middle of the payload.
    do_reset();
    for (int i = 0; i < 4; i++) push(16'($urandom));
    enable = 1; m_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1;
    cycle();
    reset = 0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_underrun", underrun, 0);
    acc.delete();
    for (int i = 0; i < 2; i++) push(16'($urandom));
    for (int i = 0; i < PKT + 1; i++) cycle();
    chk("rst_next_hdr_len", acc.size(), PKT);
    if (acc.size() != 0) chk("rst_next_hdr", acc[0], 16'hA000);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1 && fq.size() < 1000) push(16'($urandom));
      cycle();
    end
    force_empty = 0;

    // Sequence number wrap after 4096 packets.
    do_reset();
    enable = 1; m_ready = 1;
    for (int i = 0; i < 4097 * PKT + 2; i++) begin
      if (fq.size() < 8) push(16'($urandom));
      cycle();
    end
    chk("wrap_len", acc.size() > 4096 * PKT, 1);
    if (acc.size() > 4096 * PKT) begin
      chk("wrap_hdr_fff", acc[4095 * PKT], 16'hAFFF);
      chk("wrap_hdr_000", acc[4096 * PKT], 16'hA000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
